fetch_queue_pc: RTL and testbench
=================================

// Module: fetch_queue_pc
// PURPOSE
//  Parametrised fetch stage: PC register, next-PC selection, and a DEPTH-entry
//  instruction queue between the icache (ihit handshake) and decode.
//  Decouples icache stalls from decode back-pressure. Replaces the single-register PC block.
//  Redirects (taken branch, j/jal, jr) flush the queue and restart fetch at the target.
// PARAMETERS
//  DEPTH     4        queue entries; power of 2, >=2
//  RESET_PC  32'h0    PC value loaded by reset
//  CNT_W     32       width of perf counters (FETCH_PERF_EN only)
// PORTS
//  CLK        in   1   clock, all state updates on posedge
//  RST        in   1   synchronous active-high reset
//  imemREN    out  1   icache read request
//  imemaddr   out  32  fetch address, equals current PC register
//  ihit       in   1   icache hit; imemload valid this cycle
//  imemload   in   32  instruction returned by icache
//  halt       in   1   stop issuing new fetches (queue still drains)
//  PCSrc      in   2   pcsrc_t redirect select: 0 none, 1 branch, 2 jump, 3 jr
//  rd_npc     in   32  PC+4 of the redirecting instruction
//  imm        in   16  branch offset (words), sign-extended
//  jaddr      in   26  jump target field
//  jraddr     in   32  jr target
//  out_valid  out  1   queue head valid
//  out_instr  out  32  queue head instruction
//  out_npc    out  32  PC+4 of queue head
//  out_ready  in   1   decode accepts head this cycle
//  count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset: PC=RESET_PC, queue empty, count=0, out_valid=0, out_instr=0, out_npc=0.
//  - imemREN = !RST && !halt && (count < DEPTH) && (PCSrc == 0); no dependence on out_ready.
//  - Push: imemREN && ihit -> write {imemload, PC+4} at tail, PC <= PC+4 next cycle.
//    Latency: instr visible on out_* the cycle after ihit.
//  - Pop: out_valid && out_ready -> head advances. Push+pop same cycle: count unchanged.
//  - Full (count==DEPTH): imemREN=0, PC holds; a pop that cycle re-enables next cycle.
//  - Empty: out_valid=0, out_instr/out_npc are don't-care; out_ready ignored.
//  - Redirect (PCSrc != 0) has priority over push and pop:
//      branch: PC <= rd_npc + ({{14{imm[15]}}, imm, 2'b00})   (32-bit, wraps mod 2^32)
//      jump:   PC <= {rd_npc[31:28], jaddr, 2'b00}
//      jr:     PC <= jraddr
//    Queue flushed (count=0, out_valid=0 next cycle); any ihit data that cycle discarded.
//    Fetch resumes at the target the following cycle.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally; count distinguishes full/empty.
//  - halt: PC frozen, no pushes; pops continue; redirect still updates PC and flushes.
//  - RST mid-fetch: outstanding request dropped, all state to reset values same edge.
// CONFIGURATION
//  FETCH_PERF_EN defined: extra outputs stall_cnt, flush_cnt (CNT_W each), reset to 0.
//    stall_cnt +1 on each cycle imemREN && !ihit; flush_cnt +1 on each redirect cycle;
//    both saturate at all-ones.
//  Not defined: ports and counters absent; functional behaviour identical.
// TESTING
//  1 RST high 1 cycle, RESET_PC=0 -> imemaddr=0, imemREN=1, count=0, out_valid=0.
//  2 ihit=1 every cycle, out_ready=0, DEPTH=4 -> 4 pushes (0,4,8,C), count=4, imemREN=0,
//    imemaddr=0x10 held; then one pop -> head out_npc=8, fetch of 0x10 issued next cycle.
//  3 Queue full, out_ready=1 and ihit=1 continuously -> count stays at steady value, in-order
//    out_npc 4,8,C,... with no gaps or duplicates.
//  4 Branch: PCSrc=1, rd_npc=0x100, imm=16'hFFFE, ihit=1 same cycle -> next cycle PC=0xF8,
//    count=0, out_valid=0, discarded ihit word never appears on out_instr.
//  5 Jump PCSrc=2, rd_npc=0x8000_0040, jaddr=26'h10 -> PC=0x8000_0040; jr PCSrc=3,
//    jraddr=0x400 -> PC=0x400.
//  6 halt=1 with 2 entries queued, out_ready=1 -> imemREN=0, 2 pops, PC unchanged;
//    with FETCH_PERF_EN, 3 cycles ihit=0 -> stall_cnt=3, one redirect -> flush_cnt=1.

Source files
------------

// File: rtl/fetch_queue_pc.sv
// Fetch stage: PC register, next-PC selection and a DEPTH-entry instruction queue.
// Optional perf counters (stall_cnt, flush_cnt) are built when FETCH_PERF_EN is defined.
module fetch_queue_pc #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          CNT_W    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic                     imemREN,
  output logic [31:0]              imemaddr,
  input  logic                     ihit,
  input  logic [31:0]              imemload,
  input  logic                     halt,
  input  logic [1:0]               PCSrc,
  input  logic [31:0]              rd_npc,
  input  logic [15:0]              imm,
  input  logic [25:0]              jaddr,
  input  logic [31:0]              jraddr,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_npc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    PC_NONE   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pcsrc_t;

  pcsrc_t            pc_sel;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic [31:0]       branch_off;
  logic [31:0]       target;
  logic              redirect;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    occ;
  logic [63:0]       mem [DEPTH];

  assign pc_sel     = pcsrc_t'(PCSrc);
  assign redirect   = (pc_sel != PC_NONE);
  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{imm[15]}}, imm, 2'b00};

  assign imemREN  = !RST && !halt && (occ < FULL_COUNT) && !redirect;
  assign imemaddr = pc;
  assign push     = imemREN && ihit;
  assign out_valid = (occ != '0);
  assign pop      = out_valid && out_ready && !redirect;
  assign count    = occ;

  // Empty queue presents zeros so the reset-state outputs are well defined.
  assign out_instr = out_valid ? mem[head][63:32] : 32'h0;
  assign out_npc   = out_valid ? mem[head][31:0]  : 32'h0;

  always_comb begin
    target = pc;
    case (pc_sel)
      PC_BRANCH: target = rd_npc + branch_off;
      PC_JUMP:   target = {rd_npc[31:28], jaddr, 2'b00};
      PC_JR:     target = jraddr;
      default:   target = pc;
    endcase
  end

  // A redirect wins over push and pop: it flushes the queue and any word returned that cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc   <= RESET_PC;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (redirect) begin
      pc   <= target;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        pc   <= pc_plus4;
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[tail] <= {imemload, pc_plus4};
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (imemREN && !ihit && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_pc.sv
// Scoreboard bench for fetch_queue_pc: a bench-side PC/queue model predicts every output.
// Perf counter checks are compiled in when FETCH_PERF_EN is defined.
module tb_fetch_queue_pc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        halt = 1'b0;
  logic [1:0]  PCSrc = 2'd0;
  logic [31:0] rd_npc = 32'h0;
  logic [15:0] imm = 16'h0;
  logic [25:0] jaddr = 26'h0;
  logic [31:0] jraddr = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_npc;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb [$];
  logic [31:0] m_pc;
  logic        m_ren;
  int          m_stall;
  int          m_flush;

  fetch_queue_pc #(.DEPTH(4), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .halt(halt), .PCSrc(PCSrc),
    .rd_npc(rd_npc), .imm(imm), .jaddr(jaddr), .jraddr(jraddr),
    .out_valid(out_valid), .out_instr(out_instr), .out_npc(out_npc),
    .out_ready(out_ready), .count(count)
`ifdef FETCH_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    m_ren = !halt && (sb.size() < 4) && (PCSrc == 2'd0);
    check("imemREN", 64'(imemREN), 64'(m_ren));
    check("imemaddr", 64'(imemaddr), 64'(m_pc));
    check("count", 64'(count), 64'(sb.size()));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) check("head", {out_instr, out_npc}, sb[0]);
`ifdef FETCH_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  // One clock of stimulus: drive at negedge, check, advance the model, then cross posedge.
  task automatic apply_stimulus(input logic hit, input logic hlt, input logic [1:0] src,
                                input logic rdy);
    @(negedge CLK);
    RST       = 1'b0;
    ihit      = hit;
    halt      = hlt;
    PCSrc     = src;
    out_ready = rdy;
    imemload  = $urandom;
    #1;
    check_output();
    if (src != 2'd0) begin
      case (src)
        2'd1:    m_pc = rd_npc + 32'($signed(imm)) * 32'd4;
        2'd2:    m_pc = (rd_npc & 32'hF000_0000) | (32'(jaddr) << 2);
        default: m_pc = jraddr;
      endcase
      sb.delete();
      m_flush++;
    end else begin
      if ((sb.size() != 0) && rdy) void'(sb.pop_front());
      if (m_ren && hit) begin
        sb.push_back({imemload, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
      if (m_ren && !hit) m_stall++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST   = 1'b1;
    ihit  = 1'b1;
    PCSrc = 2'd0;
    #1;
    check("rst_imemREN", 64'(imemREN), 64'(0));
    @(posedge CLK);
    #1;
    sb.delete();
    m_pc    = 32'h0;
    m_stall = 0;
    m_flush = 0;
    check("rst_count", 64'(count), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_instr", 64'(out_instr), 64'(0));
    check("rst_out_npc", 64'(out_npc), 64'(0));
    check("rst_pc", 64'(imemaddr), 64'(0));
`ifdef FETCH_PERF_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    check("rst_flush_cnt", 64'(flush_cnt), 64'(0));
`endif
  endtask

  initial begin
    m_pc = 32'h0; m_ren = 1'b0; m_stall = 0; m_flush = 0;
    do_reset();

    // Fill to full with decode stalled, then one pop re-enables fetch of 0x10.
    repeat (5) apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    check("full_count", 64'(count), 64'(4));
    check("full_pc", 64'(imemaddr), 64'h10);
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b1);
    check("head_after_pop", 64'(out_npc), 64'h8);
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);

    // Steady streaming with push and pop together.
    repeat (10) apply_stimulus(1'b1, 1'b0, 2'd0, 1'b1);

    // Branch backwards with an ihit in the same cycle that must be discarded.
    rd_npc = 32'h100; imm = 16'hFFFE;
    apply_stimulus(1'b1, 1'b0, 2'd1, 1'b1);
    check("branch_pc", 64'(imemaddr), 64'hF8);
    check("branch_flush", 64'(count), 64'(0));
    repeat (3) apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);

    // Branch target wrapping below zero.
    rd_npc = 32'h4; imm = 16'hFFF0;
    apply_stimulus(1'b0, 1'b0, 2'd1, 1'b0);
    check("branch_wrap_pc", 64'(imemaddr), 64'hFFFF_FFC4);
    repeat (2) apply_stimulus(1'b1, 1'b0, 2'd0, 1'b1);

    rd_npc = 32'h8000_0040; jaddr = 26'h10;
    apply_stimulus(1'b1, 1'b0, 2'd2, 1'b0);
    check("jump_pc", 64'(imemaddr), 64'h8000_0040);
    jraddr = 32'h400;
    apply_stimulus(1'b1, 1'b0, 2'd3, 1'b0);
    check("jr_pc", 64'(imemaddr), 64'h400);

    // Halt with two entries queued: drains, no fetches, PC frozen.
    repeat (2) apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    repeat (3) apply_stimulus(1'b1, 1'b1, 2'd0, 1'b1);
    check("halt_pc", 64'(imemaddr), 64'h408);
    check("halt_drained", 64'(out_valid), 64'(0));
    jraddr = 32'h200;
    apply_stimulus(1'b1, 1'b1, 2'd3, 1'b0);
    check("halt_jr_pc", 64'(imemaddr), 64'h200);

    // Icache misses, then a random mix of hits and back-pressure.
    repeat (3) apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'b0, 2'd0, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of fetching.
    repeat (2) apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    do_reset();
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
